// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared constants for the interrupt controller:
//   - configuration register addresses (MASK, MODE, PENDING, STATUS, OVERFLOW)
//   - FSM state encoding (IDLE / REQ / GAP)
//   - STATUS register bit positions
// Optional feature macro used by the controller: INTC_OVERFLOW_EN
// -----------------------------------------------------------------------------
package intc_pkg;

  // Register map
  localparam int unsigned INTC_MASK = 0;  // 1 = channel enabled
  localparam int unsigned INTC_MODE = 1;  // 1 = edge, 0 = level
  localparam int unsigned INTC_PEND = 2;  // pending, write-1-to-clear
  localparam int unsigned INTC_STAT = 3;  // read-only request status
  localparam int unsigned INTC_OVF  = 4;  // sticky overflow (optional)

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // STATUS register layout
  localparam int unsigned STAT_REQ_BIT = 15;  // mirrors irq_req
  localparam int unsigned STAT_VEC_LSB = 0;   // irq_vec starts here

endpackage

// File: rtl/intc_prio_enc.sv
// -----------------------------------------------------------------------------
// intc_prio_enc
// Combinational find-first-set: reports whether any request bit is set and the
// index of the lowest set bit (lowest index = highest priority).
// Ports:
//   req   in  N_IRQ : candidate request bits
//   any   out 1     : at least one bit of req is set
//   index out VEC_W : index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module intc_prio_enc #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic             any,
  output logic [VEC_W-1:0] index
);

  always_comb begin
    any   = |req;
    index = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Maskable, fixed-priority interrupt controller. Merges N_IRQ synchronous
// interrupt lines into one request plus an encoded vector, with a one-cycle
// acknowledge handshake from the cpu. Configuration/status via a small
// register port.
//
// Ports:
//   clk        in  1      : system clock
//   reset      in  1      : synchronous, active-high reset
//   irq_in     in  N_IRQ  : raw interrupt lines (synchronous to clk)
//   cfg_we     in  1      : configuration write strobe
//   cfg_addr   in  CFG_AW : register select
//   cfg_wdata  in  16     : write data
//   cfg_rdata  out 16     : combinational read data for cfg_addr
//   irq_req    out 1      : interrupt request to the cpu
//   irq_vec    out VEC_W  : requested channel, valid while irq_req=1
//   irq_ack    in  1      : cpu accepts the current vector (one-cycle pulse)
//   pending    out N_IRQ  : pending register (debug)
//
// Optional feature: define INTC_OVERFLOW_EN to build the sticky OVERFLOW
// register at address 4. Without it, address 4 reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int N_IRQ  = 8,
  parameter int VEC_W  = 3,
  parameter int CFG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              irq_req,
  output logic [VEC_W-1:0]  irq_vec,
  input  logic              irq_ack,
  output logic [N_IRQ-1:0]  pending
);

  logic [N_IRQ-1:0] irq_q_reg;
  logic [N_IRQ-1:0] mask_reg;
  logic [N_IRQ-1:0] mode_reg;
  logic [N_IRQ-1:0] pending_reg;
  logic [N_IRQ-1:0] pending_next;
  logic [1:0]       state_reg;
  logic [VEC_W-1:0] vec_reg;

  logic [N_IRQ-1:0] edge_set;
  logic [N_IRQ-1:0] w1c_pend;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] eligible;
  logic             win_any;
  logic [VEC_W-1:0] win_idx;

  logic wr_mask;
  logic wr_mode;
  logic wr_pend;

  // Only the low N_IRQ bits of the write data are stored.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  assign wr_mask = cfg_we && (cfg_addr == CFG_AW'(INTC_MASK));
  assign wr_mode = cfg_we && (cfg_addr == CFG_AW'(INTC_MODE));
  assign wr_pend = cfg_we && (cfg_addr == CFG_AW'(INTC_PEND));

  // Rising edge relative to the previous cycle's sample.
  assign edge_set = irq_in & ~irq_q_reg;
  assign w1c_pend = wr_pend ? cfg_wdata[N_IRQ-1:0] : '0;
  assign ack_clr  = ((state_reg == ST_REQ) && irq_ack) ? (N_IRQ'(1) << vec_reg) : '0;
  assign clr      = w1c_pend | ack_clr;

  // Edge channels: set wins over a same-cycle clear so no event is lost.
  // Level channels simply follow the line; clears have no lasting effect.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_chan
      assign pending_next[gi] = mode_reg[gi]
                              ? (edge_set[gi] | (pending_reg[gi] & ~clr[gi]))
                              : irq_in[gi];
    end
  endgenerate

  assign eligible = pending_reg & mask_reg;

  intc_prio_enc #(
    .N_IRQ (N_IRQ),
    .VEC_W (VEC_W)
  ) u_prio_enc (
    .req   (eligible),
    .any   (win_any),
    .index (win_idx)
  );

  // Channel state and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q_reg   <= '0;
      mask_reg    <= '0;
      mode_reg    <= '1;
      pending_reg <= '0;
    end else begin
      irq_q_reg   <= irq_in;
      pending_reg <= pending_next;
      if (wr_mask) begin
        mask_reg <= cfg_wdata[N_IRQ-1:0];
      end
      if (wr_mode) begin
        mode_reg <= cfg_wdata[N_IRQ-1:0];
      end
    end
  end

  // Request handshake FSM. The vector is latched on entry to REQ and held
  // there regardless of later mask/pending changes, so the cpu never sees a
  // request withdrawn. GAP gives the pending update one cycle to settle
  // before the next arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      vec_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_any) begin
            vec_reg   <= win_idx;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_req = (state_reg == ST_REQ);
  assign irq_vec = vec_reg;
  assign pending = pending_reg;

`ifdef INTC_OVERFLOW_EN
  logic [N_IRQ-1:0] ovf_reg;
  logic [N_IRQ-1:0] ovf_set;
  logic [N_IRQ-1:0] ovf_w1c;

  // A fresh edge on an edge channel that is still pending and not being
  // cleared this cycle means an event was merged into the existing one.
  assign ovf_set = mode_reg & edge_set & pending_reg & ~clr;
  assign ovf_w1c = (cfg_we && (cfg_addr == CFG_AW'(INTC_OVF))) ? cfg_wdata[N_IRQ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg <= '0;
    end else begin
      ovf_reg <= ovf_set | (ovf_reg & ~ovf_w1c);
    end
  end
`endif

  // Combinational register read
  always_comb begin
    cfg_rdata = 16'h0000;
    case (cfg_addr)
      CFG_AW'(INTC_MASK): cfg_rdata = 16'(mask_reg);
      CFG_AW'(INTC_MODE): cfg_rdata = 16'(mode_reg);
      CFG_AW'(INTC_PEND): cfg_rdata = 16'(pending_reg);
      CFG_AW'(INTC_STAT): begin
        cfg_rdata[STAT_REQ_BIT]                      = irq_req;
        cfg_rdata[STAT_VEC_LSB +: VEC_W]             = vec_reg;
      end
`ifdef INTC_OVERFLOW_EN
      CFG_AW'(INTC_OVF):  cfg_rdata = 16'(ovf_reg);
`endif
      default:            cfg_rdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed, self-checking bench for interrupt_controller (N_IRQ=8, VEC_W=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, i.e. they reflect the state after the most recent edge.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        irq_req;
  logic [2:0]  irq_vec;
  logic        irq_ack;
  logic [7:0]  pending;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ovf;

  interrupt_controller #(
    .N_IRQ  (8),
    .VEC_W  (3),
    .CFG_AW (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = 16'h0000;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; irq_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", irq_req); end
    checks++; if (irq_vec !== 3'd0) begin errors++; $display("FAIL reset_vec got %0d want 0", irq_vec); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending); end
    cfg_addr = 3'd0; #1;
    checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL reset_mask got %h want 0000", cfg_rdata); end
    cfg_addr = 3'd1; #1;
    checks++; if (cfg_rdata !== 16'h00FF) begin errors++; $display("FAIL reset_mode got %h want 00ff", cfg_rdata); end
    cfg_addr = 3'd3; #1;
    checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL reset_status got %h want 0000", cfg_rdata); end
    $display("test_reset done");
  endtask

  task automatic test_regs();
    cfg_write(3'd0, 16'hFFFF);
    cfg_addr = 3'd0; #1;
    checks++; if (cfg_rdata !== 16'h00FF) begin errors++; $display("FAIL mask_upper_bits got %h want 00ff", cfg_rdata); end
    cfg_write(3'd5, 16'hABCD);
    cfg_addr = 3'd5; #1;
    checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL addr5_read got %h want 0000", cfg_rdata); end
    $display("test_regs done");
  endtask

  task automatic test_basic();
    irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    checks++; if (pending !== 8'h20 || irq_req !== 1'b0) begin errors++; $display("FAIL basic_edge_k pend %h req %b want 20 0", pending, irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin errors++; $display("FAIL basic_req req %b vec %0d want 1 5", irq_req, irq_vec); end
    cfg_addr = 3'd3; #1;
    checks++; if (cfg_rdata !== 16'h8005) begin errors++; $display("FAIL basic_status got %h want 8005", cfg_rdata); end
    do_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL basic_ack req %b pend %h want 0 00", irq_req, pending); end
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_stay_low got %b want 0", irq_req); end
    $display("test_basic done");
  endtask

  task automatic test_priority();
    irq_in = 8'h44;
    tick();
    irq_in = 8'h00;
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd2) begin errors++; $display("FAIL prio_first req %b vec %0d want 1 2", irq_req, irq_vec); end
    do_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h40) begin errors++; $display("FAIL prio_gap req %b pend %h want 0 40", irq_req, pending); end
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_idle got %b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd6) begin errors++; $display("FAIL prio_second req %b vec %0d want 1 6", irq_req, irq_vec); end
    do_ack();
    tick(); tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL prio_done req %b pend %h want 0 00", irq_req, pending); end
    $display("test_priority done");
  endtask

  task automatic test_level();
    cfg_write(3'd1, 16'h00F7);
    irq_in = 8'h08;
    tick();
    checks++; if (pending !== 8'h08 || irq_req !== 1'b0) begin errors++; $display("FAIL level_pend pend %h req %b want 08 0", pending, irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd3) begin errors++; $display("FAIL level_req req %b vec %0d want 1 3", irq_req, irq_vec); end
    do_ack();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h08) begin errors++; $display("FAIL level_ack req %b pend %h want 0 08", irq_req, pending); end
    tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd3) begin errors++; $display("FAIL level_rereq req %b vec %0d want 1 3", irq_req, irq_vec); end
    irq_in = 8'h00;
    tick();
    checks++; if (pending !== 8'h00 || irq_req !== 1'b1) begin errors++; $display("FAIL level_drop pend %h req %b want 00 1", pending, irq_req); end
    do_ack();
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL level_no_more got %b want 0", irq_req); end
    cfg_write(3'd1, 16'h00FF);
    $display("test_level done");
  endtask

  task automatic test_mask();
    cfg_write(3'd0, 16'h0000);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    checks++; if (pending !== 8'h02) begin errors++; $display("FAIL mask_pend got %h want 02", pending); end
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_blocked got %b want 0", irq_req); end
    cfg_write(3'd0, 16'h0002);
    tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd1) begin errors++; $display("FAIL mask_req req %b vec %0d want 1 1", irq_req, irq_vec); end
    cfg_write(3'd2, 16'h0002);
    checks++; if (pending !== 8'h00 || irq_req !== 1'b1 || irq_vec !== 3'd1) begin errors++; $display("FAIL mask_w1c_hold pend %h req %b vec %0d want 00 1 1", pending, irq_req, irq_vec); end
    tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL mask_hold2 got %b want 1", irq_req); end
    do_ack();
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_after_ack got %b want 0", irq_req); end
    $display("test_mask done");
  endtask

  task automatic test_set_wins();
    // MASK is 0x02 here, so channels 0 and 4 never raise a request.
    irq_in = 8'h10;
    cfg_write(3'd2, 16'h0010);
    irq_in = 8'h00;
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL set_wins got %h want 10", pending); end
    cfg_write(3'd2, 16'h0010);
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL w1c_clear got %h want 00", pending); end
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    do_ack();
    checks++; if (pending !== 8'h01 || irq_req !== 1'b0) begin errors++; $display("FAIL ack_outside_req pend %h req %b want 01 0", pending, irq_req); end
    cfg_write(3'd2, 16'h0001);
    $display("test_set_wins done");
  endtask

  task automatic test_overflow();
`ifdef INTC_OVERFLOW_EN
    exp_ovf = 16'h0001;
`else
    exp_ovf = 16'h0000;
`endif
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick();
    cfg_addr = 3'd4; #1;
    checks++; if (cfg_rdata !== exp_ovf) begin errors++; $display("FAIL ovf_set got %h want %h", cfg_rdata, exp_ovf); end
    cfg_write(3'd4, 16'h0001);
    cfg_addr = 3'd4; #1;
    checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL ovf_w1c got %h want 0000", cfg_rdata); end
    // pending[0] is still set; a new edge together with its clear is not an overflow
    irq_in = 8'h01;
    cfg_write(3'd2, 16'h0001);
    irq_in = 8'h00;
    cfg_addr = 3'd4; #1;
    checks++; if (cfg_rdata !== 16'h0000 || pending !== 8'h01) begin errors++; $display("FAIL ovf_clear_cycle ovf %h pend %h want 0000 01", cfg_rdata, pending); end
    cfg_write(3'd2, 16'h0001);
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid();
    cfg_write(3'd0, 16'h00FF);
    irq_in = 8'h80;
    tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_vec !== 3'd7) begin errors++; $display("FAIL rst_mid_pre req %b vec %0d want 1 7", irq_req, irq_vec); end
    reset = 1'b1;
    tick();
    checks++; if (irq_req !== 1'b0 || irq_vec !== 3'd0 || pending !== 8'h00) begin errors++; $display("FAIL rst_mid_clear req %b vec %0d pend %h want 0 0 00", irq_req, irq_vec, pending); end
    reset = 1'b0;
    tick();
    checks++; if (pending !== 8'h80) begin errors++; $display("FAIL rst_held_edge got %h want 80", pending); end
    irq_in = 8'h00;
    tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_mask_cleared got %b want 0", irq_req); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic();
    test_priority();
    test_level();
    test_mask();
    test_set_wins();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised, maskable, prioritising interrupt controller.
- Replaces the plain OR-and-register of timer and I/O interrupt lines feeding the cpu core.
- Merges N_IRQ synchronous sources (timer, i_o_manager, future peripherals) into one request plus an encoded vector, with an acknowledge handshake.
- Configuration and status are reached through a small register port driven by the cpu's memory-mapped I/O path.

Parameters:
- N_IRQ, 8: number of interrupt channels, 1..16.
- VEC_W, 3: vector width; must equal clog2(N_IRQ), minimum 1.
- CFG_AW, 3: configuration address width.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- irq_in  in  N_IRQ: raw interrupt lines, already synchronous to clk.
- cfg_we  in  1: configuration write strobe, one cycle.
- cfg_addr  in  CFG_AW: register select.
- cfg_wdata  in  16: write data.
- cfg_rdata  out  16: combinational read data for cfg_addr.
- irq_req  out  1: interrupt request to the cpu.
- irq_vec  out  VEC_W: channel number being requested; valid while irq_req=1.
- irq_ack  in  1: cpu accepts the current vector, one-cycle pulse.
- pending  out  N_IRQ: pending register, for debug LEDs.

Behaviour:
- Registers. Bits at or above N_IRQ read 0 and ignore writes.
  - addr 0 MASK: 1 = enabled. Reset 0.
  - addr 1 MODE: 1 = edge, 0 = level. Reset all-ones.
  - addr 2 PENDING: read; write-1-to-clear. Reset 0.
  - addr 3 STATUS: read-only; [15] = irq_req, [VEC_W-1:0] = irq_vec.
  - Other addresses read 0.
- Edge sampling: irq_q <= irq_in every cycle; reset value 0.
- Edge channel: pending[i] is set at the clock edge where irq_in[i]=1 and irq_q[i]=0. It stays set until ack or a W1C write.
- Level channel: pending[i] <= irq_in[i] every cycle. Ack and W1C have no lasting effect on it.
- Set/clear conflict: a set and a clear on the same bit in the same cycle resolve to set, so no event is lost.
- Eligible set: pending & MASK. Priority is fixed; lowest index wins.
- FSM states:
  - IDLE: irq_req=0. If the eligible set is non-empty, latch the winning vector into irq_vec and go to REQ.
  - REQ: irq_req=1 and irq_vec held stable. No withdrawal, even if the bit is later masked or cleared. On irq_ack, clear pending[irq_vec] if that channel is edge mode, then go to GAP.
  - GAP: irq_req=0 for exactly one cycle, so the pending update is visible. Then go to IDLE.
- Latency: irq_in rises at edge k, so pending is set at edge k and irq_req=1 after edge k+1. Ack at edge m gives irq_req=0 after m. The next request can appear after m+2.
- irq_ack outside REQ is ignored.
- A MASK write takes effect for the next IDLE decision only.
- Reset mid-operation: FSM returns to IDLE and all outputs clear the cycle after reset. The irq_q reset value of 0 means a line held high through reset produces one edge event after reset is released.

Optional Feature:
- INTC_OVERFLOW_EN defined: addr 4 OVERFLOW register, N_IRQ sticky bits, write-1-to-clear, reset 0.
  - Bit i sets when a new edge arrives on an edge-mode channel whose pending[i] is already 1 and is not being cleared that cycle.
  - If the channel is being cleared in the same cycle, no overflow is recorded.
- Not defined: addr 4 reads 0; writes are ignored; no overflow logic is built.

Decomposition:
- Package intc_pkg holds:
  - register address constants INTC_MASK, INTC_MODE, INTC_PEND, INTC_STAT, INTC_OVF;
  - FSM state encoding IDLE/REQ/GAP;
  - STATUS bit positions.
- One sub-module, intc_prio_enc: combinational find-first-set over N_IRQ bits, outputting {any, index[VEC_W-1:0]}.

Test Plan:
- MASK=0xFF, pulse irq_in[5] for 1 cycle -> irq_req=1 two edges later with irq_vec=5; ack -> pending[5]=0, irq_req low for 1 cycle, then stays low.
- irq_in[2] and irq_in[6] rise in the same cycle -> vector 2 first; after ack and the GAP cycle, vector 6.
- MODE[3]=0 (level), hold irq_in[3]=1, ack -> re-request of vector 3 after GAP; drop irq_in[3] -> pending[3]=0 next cycle and no further request.
- MASK=0x00, pulse irq_in[1] -> pending[1]=1, irq_req stays 0; write MASK=0x02 -> request vector 1; W1C PENDING with 0x02 before ack -> irq_req still held until ack.
- Raise irq_in[4] in the same cycle as a W1C write of 0x10 -> pending[4]=1 (set wins).
- With INTC_OVERFLOW_EN, mask channel 0 and pulse it twice -> OVERFLOW=0x0001; write 0x0001 to addr 4 -> 0x0000. Without the macro, addr 4 reads 0.
